// File: rtl/bluetooth_pkg.sv
// rtl/bluetooth_pkg.sv - shared ASCII constants, status codes and decoder types
package bluetooth_pkg;

    // Uppercase ASCII letters shared by command encoder and reply decoder
    localparam logic [7:0] ASCII_A = 8'h41, ASCII_B = 8'h42, ASCII_C = 8'h43, ASCII_D = 8'h44;
    localparam logic [7:0] ASCII_E = 8'h45, ASCII_F = 8'h46, ASCII_G = 8'h47, ASCII_H = 8'h48;
    localparam logic [7:0] ASCII_I = 8'h49, ASCII_J = 8'h4A, ASCII_K = 8'h4B, ASCII_L = 8'h4C;
    localparam logic [7:0] ASCII_M = 8'h4D, ASCII_N = 8'h4E, ASCII_O = 8'h4F, ASCII_P = 8'h50;
    localparam logic [7:0] ASCII_Q = 8'h51, ASCII_R = 8'h52, ASCII_S = 8'h53, ASCII_T = 8'h54;
    localparam logic [7:0] ASCII_U = 8'h55, ASCII_V = 8'h56, ASCII_W = 8'h57, ASCII_X = 8'h58;
    localparam logic [7:0] ASCII_Y = 8'h59, ASCII_Z = 8'h5A;

    // Punctuation and line control
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_EQUAL = 8'h3D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // Line buffer geometry: five stored bytes, length saturates one past that
    localparam int         LINE_BYTES   = 5;
    localparam logic [2:0] LEN_OVERSIZE = 3'd6;

    typedef enum logic [1:0] {
        STATUS_NONE    = 2'd0,
        STATUS_OK      = 2'd1,
        STATUS_ERROR   = 2'd2,
        STATUS_TIMEOUT = 2'd3
    } status_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_e;

endpackage

// File: rtl/bluetooth_line_buffer.sv
// rtl/bluetooth_line_buffer.sv - reply line store with OK/ERROR match and packed payload
module bluetooth_line_buffer
    import bluetooth_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  data,
    output logic [2:0]  len,
    output logic        is_ok,
    output logic        is_error,
    output logic [31:0] payload
);

    logic [7:0] line_q [LINE_BYTES];
    logic [2:0] len_q;

    // Append bytes in arrival order; length keeps counting to the oversize mark
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q <= '0;
            for (int i = 0; i < LINE_BYTES; i++) line_q[i] <= '0;
        end else if (clear) begin
            len_q <= '0;
            for (int i = 0; i < LINE_BYTES; i++) line_q[i] <= '0;
        end else if (push) begin
            for (int i = 0; i < LINE_BYTES; i++) begin
                if (len_q == 3'(i)) line_q[i] <= data;
            end
            if (len_q != LEN_OVERSIZE) len_q <= len_q + 3'd1;
        end
    end

    // Terminator matches and first-byte-lowest payload, masked to the line length
    always_comb begin
        len      = len_q;
        is_ok    = (len_q == 3'd2) && (line_q[0] == ASCII_O) && (line_q[1] == ASCII_K);
        is_error = (len_q == 3'd5) && (line_q[0] == ASCII_E) && (line_q[1] == ASCII_R) &&
                   (line_q[2] == ASCII_R) && (line_q[3] == ASCII_O) && (line_q[4] == ASCII_R);
        payload  = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < len_q) payload[8*i +: 8] = line_q[i];
        end
    end

endmodule

// File: rtl/bluetooth_decoder.sv
// rtl/bluetooth_decoder.sv - parses BLE UART replies into payload, status and timeout
module bluetooth_decoder
    import bluetooth_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    input  logic        start,
    input  logic        expect_data,
    output logic [31:0] output_data,
    output logic [2:0]  data_count,
    output logic [1:0]  status,
    output logic        malformed,
    output logic        done
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] idle_cnt;
    logic             expect_q, data_seen;
    status_e          status_q;
    logic [31:0]      data_q;
    logic [2:0]       count_q;
    logic             malformed_q;

    logic             collecting, arm, line_push, line_end, line_clear;
    logic             timeout_hit, accept_data;
    logic [2:0]       line_len;
    logic             line_ok, line_error;
    logic [31:0]      line_payload;

    bluetooth_line_buffer u_line (
        .clk      (clk),
        .reset    (reset),
        .clear    (line_clear),
        .push     (line_push),
        .data     (rx_byte),
        .len      (line_len),
        .is_ok    (line_ok),
        .is_error (line_error),
        .payload  (line_payload)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Arm on start; return to idle on a terminator line or an expired idle window
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start) state_d = ST_COLLECT;
            ST_COLLECT: if ((line_end && (line_ok || line_error)) || timeout_hit) state_d = ST_IDLE;
        endcase
    end

    // Byte classification and per-cycle control decodes
    always_comb begin
        done        = (state_q == ST_IDLE);
        collecting  = (state_q == ST_COLLECT);
        arm         = done && start;
        line_push   = collecting && rx_valid && (rx_byte != ASCII_CR) && (rx_byte != ASCII_LF);
        line_end    = collecting && rx_valid && (rx_byte == ASCII_LF);
        line_clear  = arm || line_end;
        timeout_hit = collecting && !rx_valid && (idle_cnt == CNT_LAST);
        accept_data = expect_q && !data_seen && (line_len != 3'd0) && (line_len <= 3'd4);
    end

    // Idle window counter, restarted by every received byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          idle_cnt <= '0;
        else if (arm || (collecting && rx_valid)) idle_cnt <= '0;
        else if (collecting)                 idle_cnt <= idle_cnt + CNT_W'(1);
    end

    // Result registers, written only while collecting so they hold after done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            expect_q    <= 1'b0;
            data_seen   <= 1'b0;
            status_q    <= STATUS_NONE;
            data_q      <= '0;
            count_q     <= '0;
            malformed_q <= 1'b0;
        end else if (arm) begin
            expect_q    <= expect_data;
            data_seen   <= 1'b0;
            status_q    <= STATUS_NONE;
            data_q      <= '0;
            count_q     <= '0;
            malformed_q <= 1'b0;
        end else if (collecting) begin
            if (timeout_hit) status_q <= STATUS_TIMEOUT;
            if (line_end) begin
                if (line_ok) begin
                    status_q <= STATUS_OK;
                end else if (line_error) begin
                    status_q <= STATUS_ERROR;
                end else if (accept_data) begin
                    data_q    <= line_payload;
                    count_q   <= line_len;
                    data_seen <= 1'b1;
                end else if (line_len != 3'd0) begin
                    malformed_q <= 1'b1;
                end
            end
        end
    end

    assign output_data = data_q;
    assign data_count  = count_q;
    assign status      = status_q;
    assign malformed   = malformed_q;

endmodule

// File: tb/tb_bluetooth_decoder.sv
// tb/tb_bluetooth_decoder.sv - vector, corner-case and randomized model checks for bluetooth_decoder
module tb_bluetooth_decoder;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        start;
    logic        expect_data;
    logic [31:0] output_data;
    logic [2:0]  data_count;
    logic [1:0]  status;
    logic        malformed;
    logic        done;

    int checks   = 0;
    int failures = 0;

    bluetooth_decoder #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .start       (start),
        .expect_data (expect_data),
        .output_data (output_data),
        .data_count  (data_count),
        .status      (status),
        .malformed   (malformed),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       s;
        bit          exp;
        logic [31:0] od;
        logic [2:0]  cnt;
        logic [1:0]  st;
        bit          mal;
    } vec_t;

    vec_t        vecs [10];
    logic [7:0]  stim [$];
    logic [7:0]  mline [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // '~' stands for CR and '|' for LF in the readable vector strings
    function automatic logic [7:0] map_ch(input logic [7:0] c);
        if (c == 8'h7E) return 8'h0D;
        if (c == 8'h7C) return 8'h0A;
        return c;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic do_start(input bit exp);
        start       = 1'b1;
        expect_data = exp;
        tick();
        start       = 1'b0;
        expect_data = 1'b0;
    endtask

    // Sends a string back to back; every byte before the last must leave the decoder busy
    task automatic run_str(input string s, input bit check_busy);
        for (int j = 0; j < s.len(); j++) begin
            send_byte(map_ch(s[j]));
            if (check_busy && j < s.len() - 1) chk("busy_mid_reply", 32'(done), 32'd0);
        end
    endtask

    task automatic set_vec(input int i, input string s, input bit exp, input logic [31:0] od,
                           input logic [2:0] cnt, input logic [1:0] st, input bit mal);
        vecs[i].s = s; vecs[i].exp = exp; vecs[i].od = od;
        vecs[i].cnt = cnt; vecs[i].st = st; vecs[i].mal = mal;
    endtask

    task automatic chk_outputs(input string tag, input logic [31:0] od, input int cnt,
                               input int st, input bit mal);
        chk({tag, "_data"},      output_data,       od);
        chk({tag, "_count"},     32'(data_count),   32'(cnt));
        chk({tag, "_status"},    32'(status),       32'(st));
        chk({tag, "_malformed"}, 32'(malformed),    32'(mal));
    endtask

    function automatic bit line_is(input string s);
        if (mline.size() != s.len()) return 1'b0;
        for (int j = 0; j < s.len(); j++) if (mline[j] != s[j]) return 1'b0;
        return 1'b1;
    endfunction

    // Reference: whole lines kept unbounded, judged by the reply rules on each LF
    task automatic model(input bit exp, output logic [31:0] od, output int cnt, output int st,
                         output bit mal, output int end_idx);
        bit seen;
        od = '0; cnt = 0; st = 0; mal = 1'b0; end_idx = -1; seen = 1'b0;
        mline.delete();
        for (int i = 0; i < stim.size() && end_idx < 0; i++) begin
            if (stim[i] == 8'd13) continue;
            if (stim[i] != 8'd10) begin
                mline.push_back(stim[i]);
                continue;
            end
            if (mline.size() != 0) begin
                if (line_is("OK")) begin
                    st = 1; end_idx = i;
                end else if (line_is("ERROR")) begin
                    st = 2; end_idx = i;
                end else if (exp && mline.size() <= 4 && !seen) begin
                    seen = 1'b1;
                    cnt  = mline.size();
                    od   = '0;
                    for (int j = 0; j < mline.size(); j++) od[8*j +: 8] = mline[j];
                end else begin
                    mal = 1'b1;
                end
            end
            mline.delete();
        end
    endtask

    initial begin
        logic [31:0] m_od;
        int          m_cnt, m_st, m_end;
        bit          m_mal, r_exp;

        reset = 1'b0; rx_byte = 8'h00; rx_valid = 1'b0; start = 1'b0; expect_data = 1'b0;

        set_vec(0, "WIC!~|OK~|",         1'b1, 32'h21434957, 3'd4, 2'd1, 1'b0);
        set_vec(1, "OK~|",               1'b1, 32'h00000000, 3'd0, 2'd1, 1'b0);
        set_vec(2, "ERROR~|",            1'b0, 32'h00000000, 3'd0, 2'd2, 1'b0);
        set_vec(3, "ABCDEF~|XY~|OK~|",   1'b1, 32'h00005958, 3'd2, 2'd1, 1'b1);
        set_vec(4, "AB~|OK~|",           1'b0, 32'h00000000, 3'd0, 2'd1, 1'b1);
        set_vec(5, "AB~|CD~|OK~|",       1'b1, 32'h00004241, 3'd2, 2'd1, 1'b1);
        set_vec(6, "~||ERROR~|",         1'b1, 32'h00000000, 3'd0, 2'd2, 1'b0);
        set_vec(7, "ERRORX|OK|",         1'b1, 32'h00000000, 3'd0, 2'd1, 1'b1);
        set_vec(8, "HELLO|OK|",          1'b1, 32'h00000000, 3'd0, 2'd1, 1'b1);
        set_vec(9, "Z~Z|OK|",            1'b1, 32'h00005A5A, 3'd2, 2'd1, 1'b0);

        tick(); tick();
        chk_outputs("reset", 32'h0, 0, 0, 1'b0);
        chk("reset_done", 32'(done), 32'd1);
        reset = 1'b1;
        tick();

        // Table vectors, each start issued in the first idle cycle after the previous reply
        for (int i = 0; i < 10; i++) begin
            if (i > 0 && (i % 2) == 0) begin
                run_str("AB|OK|", 1'b0);
                chk("idle_ignore_status", 32'(status), 32'(vecs[i-1].st));
                chk("idle_ignore_done",   32'(done),   32'd1);
            end
            do_start(vecs[i].exp);
            chk("start_busy", 32'(done), 32'd0);
            run_str(vecs[i].s, 1'b1);
            chk("vec_done", 32'(done), 32'd1);
            chk_outputs("vec", vecs[i].od, 32'(vecs[i].cnt), 32'(vecs[i].st), vecs[i].mal);
        end

        // Outputs frozen after done even when more reply bytes arrive
        run_str("PQ|ERROR|", 1'b0);
        chk_outputs("frozen", 32'h00005A5A, 2, 1, 1'b0);

        // Silent module: abort exactly 16 edges after start
        do_start(1'b1);
        repeat (15) tick();
        chk("timeout_not_yet", 32'(done), 32'd0);
        tick();
        chk("timeout_done", 32'(done), 32'd1);
        chk("timeout_status", 32'(status), 32'd3);

        // A byte on cycle 10 restarts the 16-cycle window
        do_start(1'b1);
        repeat (9) tick();
        send_byte(8'h41);
        repeat (15) tick();
        chk("timeout_delay_not_yet", 32'(done), 32'd0);
        tick();
        chk("timeout_delay_done", 32'(done), 32'd1);
        chk("timeout_delay_status", 32'(status), 32'd3);

        // A byte on the final counting cycle cancels the abort
        do_start(1'b1);
        repeat (15) tick();
        send_byte(8'h41);
        chk("timeout_cancel_busy", 32'(done), 32'd0);
        run_str("|OK|", 1'b1);
        chk_outputs("timeout_cancel", 32'h00000041, 1, 1, 1'b0);

        // start while collecting must not restart the transaction or relatch expect_data
        do_start(1'b1);
        send_byte(8'h41);
        start = 1'b1; expect_data = 1'b0;
        send_byte(8'h42);
        start = 1'b0;
        run_str("|OK|", 1'b1);
        chk_outputs("start_ignored", 32'h00004241, 2, 1, 1'b0);

        // Asynchronous reset in idle with non-zero results
        do_start(vecs[3].exp);
        run_str(vecs[3].s, 1'b0);
        reset = 1'b0;
        #1;
        chk_outputs("idle_reset", 32'h0, 0, 0, 1'b0);
        chk("idle_reset_done", 32'(done), 32'd1);
        tick();
        reset = 1'b1;
        tick();

        // Reset mid-line after "WI", then a clean OK transaction
        do_start(1'b1);
        run_str("WI", 1'b0);
        reset = 1'b0;
        #1;
        chk("midline_reset_done", 32'(done), 32'd1);
        chk_outputs("midline_reset", 32'h0, 0, 0, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        do_start(1'b1);
        run_str("OK~|", 1'b1);
        chk_outputs("after_reset", 32'h0, 0, 1, 1'b0);
        chk("after_reset_done", 32'(done), 32'd1);

        // Randomized replies against the line-level reference
        for (int t = 0; t < 40; t++) begin
            stim.delete();
            r_exp = 1'($urandom_range(1, 0));
            for (int l = 0, nl = $urandom_range(3, 0); l < nl; l++) begin
                for (int k = 0, ln = $urandom_range(6, 0); k < ln; k++) begin
                    if ($urandom_range(9, 0) == 0) stim.push_back(8'h0D);
                    else stim.push_back(8'(32'h41 + $urandom_range(25, 0)));
                end
                if ($urandom_range(1, 0) == 1) stim.push_back(8'h0D);
                stim.push_back(8'h0A);
            end
            if ($urandom_range(1, 0) == 1) begin
                stim.push_back(8'h4F); stim.push_back(8'h4B);
            end else begin
                stim.push_back(8'h45); stim.push_back(8'h52); stim.push_back(8'h52);
                stim.push_back(8'h4F); stim.push_back(8'h52);
            end
            stim.push_back(8'h0D);
            stim.push_back(8'h0A);
            model(r_exp, m_od, m_cnt, m_st, m_mal, m_end);

            do_start(r_exp);
            for (int i = 0; i <= m_end; i++) begin
                repeat ($urandom_range(2, 0)) tick();
                send_byte(stim[i]);
                if (i < m_end) chk("rand_busy", 32'(done), 32'd0);
            end
            chk("rand_done", 32'(done), 32'd1);
            chk_outputs("rand", m_od, m_cnt, m_st, m_mal);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
